alu_instr_sequencer: RTL and testbench
======================================

// Module: alu_instr_sequencer
// PURPOSE
//  Parametrised Moore control sequencer for the datapath: fetch (T0-T2) plus execute for every ALU instruction class.
//  Replaces hand-coded per-instruction T-state benches and drives PC/MAR/MDR/IR/Y/Z/HI/LO/register-file strobes.
//  Adds start/done handshake, memory wait states with timeout, illegal-opcode trap and back-to-back issue.
// PARAMETERS
//  NUM_REGS     16   register count; rin/rout width; must be <= 16
//  ALUOP_W      4    width of alu_op
//  MEM_TIMEOUT  15   max T1 cycles waiting for mem_ready before abort (>=1)
// PORTS
//  clock       in   1         system clock; all state changes on rising edge
//  clear       in   1         synchronous active-high reset
//  start       in   1         request one instruction; sampled in IDLE and in the final execute state
//  mem_ready   in   1         memory read data valid on Mdatain this cycle
//  ir          in   32        datapath IR contents; stable from T3 to done
//  busy        out  1         high in every state except IDLE
//  done        out  1         one-cycle pulse in the final execute state
//  illegal     out  1         one-cycle pulse: opcode/field not executable
//  mem_err     out  1         one-cycle pulse: MEM_TIMEOUT expired in T1
//  pc_out, mar_in, inc_pc, pc_in, read, mdr_in, mdr_out, ir_in  out 1 each  fetch strobes
//  y_in, z_in, z_low_out, z_high_out, hi_in, lo_in, c_out       out 1 each  execute strobes
//  alu_op      out  ALUOP_W   ALU operation code
//  rin, rout   out  NUM_REGS  one-hot register load / drive enables
// BEHAVIOUR
//  - Reset: clear -> state IDLE, wait counter 0. Every output is 0 in IDLE, so all outputs are 0 on the cycle after clear.
//    clear mid-instruction aborts with no done pulse.
//  - IR fields: op=ir[31:27], ra=ir[26:23], rb=ir[22:19], rc=ir[18:15]. Decoded combinationally in T3+.
//  - Outputs decode only registered state and ir; no input-to-output combinational path except ir fields.
//  - IDLE --start--> T0: pc_out, mar_in, inc_pc, z_in.
//  - T1: z_low_out, pc_in, read, mdr_in. pc_in/z_low_out assert only in the first T1 cycle.
//    read/mdr_in are held until mem_ready. Leave T1 -> T2 on mem_ready.
//    The counter increments per non-ready cycle. At count==MEM_TIMEOUT: mem_err pulse, -> IDLE.
//  - T2: mdr_out, ir_in. -> T3.
//  - R3 class (add sub and or ror rol shr shra shl):
//    T3 rout[rb],y_in; T4 rout[rc],alu_op,z_in; T5 z_low_out,rin[ra],done.
//  - UNARY (neg not): T3 rout[rb],alu_op,z_in; T4 z_low_out,rin[ra],done.
//  - MULDIV (mul div): T3 rout[ra],y_in; T4 rout[rb],alu_op,z_in; T5 z_low_out,lo_in; T6 z_high_out,hi_in,done.
//  - Illegal trap: unmapped op, or any used field >= NUM_REGS.
//    T3 becomes ILL: illegal pulse, no rin/rout, -> IDLE.
//  - Final state (done high): start=1 -> T0 next (zero-bubble back-to-back); else -> IDLE.
//    start in other non-IDLE states is ignored.
//  - alu_op = 0 whenever not in an alu_op-asserting state. At most one of rout/mdr_out/z_*_out/c_out/pc_out is high per cycle.
// CONFIGURATION
//  - Macro IMM_OPS_EN: when defined, addi/andi/ori execute as T3 rout[rb],y_in; T4 c_out,alu_op,z_in; T5 z_low_out,rin[ra],done.
//    When undefined, those opcodes take the illegal trap and c_out is tied 0.
// STRUCTURE
//  - Package alu_seq_pkg:
//    state enum (IDLE,T0..T6,ILL); opcode constants; ALU op constants (ALU_ROL=4'd9 etc.);
//    class enum (R3,UNARY,MULDIV,IMM,BAD); function op_class(op) and function op_to_aluop(op).
//  - One sub-module alu_seq_decode: op -> {class, alu_op}, purely combinational, reused by the control unit later.
// TESTING
//  - clear=1 two cycles, start=1 -> busy=0 and all strobes 0 while clear; T0 strobes appear the cycle after clear drops.
//  - rol R7,R0,R4: ir=32'h43820000, mem_ready=1 in T1.
//    Response: T3 rout[0],y_in; T4 rout[4],alu_op=4'd9,z_in; T5 rin[7],done. Done arrives 6 cycles after start.
//    In-system with R0=9, R4=2: R7=32'h24.
//  - mem_ready low 3 cycles: T1 lasts 4 cycles, pc_in only in the first.
//    mem_ready never high, MEM_TIMEOUT=15: mem_err after 15 T1 cycles, then IDLE.
//  - mul R2,R3 followed by start held high: LO then HI strobes in T5/T6, done in T6, next cycle T0 (no IDLE).
//  - op=5'h1F -> illegal pulse in the T3 slot, no rin bit ever set.
//    addi with IMM_OPS_EN undefined -> illegal; defined -> c_out in T4.
//  - clear asserted in T4 of add -> IDLE next cycle, no done, no rin pulse.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU instruction sequencer.
// The state and class enums, the opcode map, the ALU operation codes and the opcode helper
// functions live here.
// Optional feature macro: IMM_OPS_EN makes addi/andi/ori executable. When it is undefined,
// those opcodes decode as BAD.
package alu_seq_pkg;

    typedef enum logic [3:0] {IDLE, T0, T1, T2, T3, T4, T5, T6, ILL} state_t;

    typedef enum logic [2:0] {R3, UNARY, MULDIV, IMM, BAD} op_class_t;

    localparam logic [4:0] OP_ADD  = 5'd3;
    localparam logic [4:0] OP_SUB  = 5'd4;
    localparam logic [4:0] OP_AND  = 5'd5;
    localparam logic [4:0] OP_OR   = 5'd6;
    localparam logic [4:0] OP_ROR  = 5'd7;
    localparam logic [4:0] OP_ROL  = 5'd8;
    localparam logic [4:0] OP_SHR  = 5'd9;
    localparam logic [4:0] OP_SHRA = 5'd10;
    localparam logic [4:0] OP_SHL  = 5'd11;
    localparam logic [4:0] OP_ADDI = 5'd12;
    localparam logic [4:0] OP_ANDI = 5'd13;
    localparam logic [4:0] OP_ORI  = 5'd14;
    localparam logic [4:0] OP_MUL  = 5'd15;
    localparam logic [4:0] OP_DIV  = 5'd16;
    localparam logic [4:0] OP_NEG  = 5'd17;
    localparam logic [4:0] OP_NOT  = 5'd18;

    localparam logic [3:0] ALU_NOP  = 4'd0;
    localparam logic [3:0] ALU_ADD  = 4'd1;
    localparam logic [3:0] ALU_SUB  = 4'd2;
    localparam logic [3:0] ALU_AND  = 4'd3;
    localparam logic [3:0] ALU_OR   = 4'd4;
    localparam logic [3:0] ALU_SHR  = 4'd5;
    localparam logic [3:0] ALU_SHRA = 4'd6;
    localparam logic [3:0] ALU_SHL  = 4'd7;
    localparam logic [3:0] ALU_ROR  = 4'd8;
    localparam logic [3:0] ALU_ROL  = 4'd9;
    localparam logic [3:0] ALU_MUL  = 4'd10;
    localparam logic [3:0] ALU_DIV  = 4'd11;
    localparam logic [3:0] ALU_NEG  = 4'd12;
    localparam logic [3:0] ALU_NOT  = 4'd13;

    function automatic op_class_t op_class(input logic [4:0] op);
        op_class_t cls;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR,
            OP_ROL, OP_SHR, OP_SHRA, OP_SHL:        cls = R3;
            OP_NEG, OP_NOT:                         cls = UNARY;
            OP_MUL, OP_DIV:                         cls = MULDIV;
`ifdef IMM_OPS_EN
            OP_ADDI, OP_ANDI, OP_ORI:               cls = IMM;
`endif
            default:                                cls = BAD;
        endcase
        return cls;
    endfunction

    function automatic logic [3:0] op_to_aluop(input logic [4:0] op);
        logic [3:0] code;
        case (op)
            OP_ADD, OP_ADDI: code = ALU_ADD;
            OP_SUB:          code = ALU_SUB;
            OP_AND, OP_ANDI: code = ALU_AND;
            OP_OR, OP_ORI:   code = ALU_OR;
            OP_ROR:          code = ALU_ROR;
            OP_ROL:          code = ALU_ROL;
            OP_SHR:          code = ALU_SHR;
            OP_SHRA:         code = ALU_SHRA;
            OP_SHL:          code = ALU_SHL;
            OP_MUL:          code = ALU_MUL;
            OP_DIV:          code = ALU_DIV;
            OP_NEG:          code = ALU_NEG;
            OP_NOT:          code = ALU_NOT;
            default:         code = ALU_NOP;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/alu_instr_sequencer_if.sv
// Handshake and strobe bundle between the instruction sequencer and the datapath.
// The master modport is the requester/datapath side, and the slave modport is the sequencer.
interface alu_instr_sequencer_if #(
    parameter int NUM_REGS = 16,
    parameter int ALUOP_W  = 4
);
    logic                start;
    logic                mem_ready;
    logic [31:0]         ir;
    logic                busy;
    logic                done;
    logic                illegal;
    logic                mem_err;
    logic                pc_out, mar_in, inc_pc, pc_in, read, mdr_in, mdr_out, ir_in;
    logic                y_in, z_in, z_low_out, z_high_out, hi_in, lo_in, c_out;
    logic [ALUOP_W-1:0]  alu_op;
    logic [NUM_REGS-1:0] rin;
    logic [NUM_REGS-1:0] rout;

    modport master (
        output start, mem_ready, ir,
        input  busy, done, illegal, mem_err,
        input  pc_out, mar_in, inc_pc, pc_in, read, mdr_in, mdr_out, ir_in,
        input  y_in, z_in, z_low_out, z_high_out, hi_in, lo_in, c_out,
        input  alu_op, rin, rout
    );

    modport slave (
        input  start, mem_ready, ir,
        output busy, done, illegal, mem_err,
        output pc_out, mar_in, inc_pc, pc_in, read, mdr_in, mdr_out, ir_in,
        output y_in, z_in, z_low_out, z_high_out, hi_in, lo_in, c_out,
        output alu_op, rin, rout
    );
endinterface

// File: rtl/alu_seq_decode.sv
// Opcode decoder that maps an opcode to its execution class and its ALU operation code.
// It is purely combinational, so the control unit can reuse it.
// The class map follows IMM_OPS_EN through alu_seq_pkg::op_class.
module alu_seq_decode
    import alu_seq_pkg::*;
#(
    parameter int ALUOP_W = 4
) (
    input  logic [4:0]         op,
    output op_class_t          cls,
    output logic [ALUOP_W-1:0] alu_op
);

    assign cls    = op_class(op);
    assign alu_op = ALUOP_W'(op_to_aluop(op));

endmodule

// File: rtl/alu_instr_sequencer.sv
// Moore control sequencer. It runs the instruction fetch (T0-T2), waits on memory with a
// timeout, and then runs the per-class execute steps that drive the datapath strobes.
// Optional feature macro: IMM_OPS_EN enables addi/andi/ori, and only those opcodes assert c_out.
//
// state | meaning
// IDLE  | waiting for start; every output low
// T0    | PC -> MAR, increment PC into Z
// T1    | memory read; wait for mem_ready, abort with mem_err on timeout
// T2    | MDR -> IR
// T3-T6 | execute steps; the step contents depend on the opcode class
// ILL   | T3 slot of an unexecutable instruction; illegal pulse, then IDLE
module alu_instr_sequencer
    import alu_seq_pkg::*;
#(
    parameter int NUM_REGS    = 16,
    parameter int ALUOP_W     = 4,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                  clock,
    input  logic                  clear,
    alu_instr_sequencer_if.slave  bus
);

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

    state_t             state;
    logic [CNT_W-1:0]   wait_cnt;
    op_class_t          cls;
    logic [ALUOP_W-1:0] dec_alu_op;
    logic [3:0]         ra, rb, rc;
    logic               bad, timeout, last_step;
    logic               unused_ir;

    assign ra = bus.ir[26:23];
    assign rb = bus.ir[22:19];
    assign rc = bus.ir[18:15];
    assign unused_ir = ^bus.ir[14:0];

    alu_seq_decode #(.ALUOP_W(ALUOP_W)) u_decode (
        .op     (bus.ir[31:27]),
        .cls    (cls),
        .alu_op (dec_alu_op)
    );

    // rc is only a source operand for three-register instructions.
    assign bad = (cls == BAD) || (int'(ra) >= NUM_REGS) || (int'(rb) >= NUM_REGS)
               || ((cls == R3) && (int'(rc) >= NUM_REGS));
    assign timeout   = (state == T1) && (wait_cnt == CNT_W'(MEM_TIMEOUT));
    assign last_step = ((state == T4) && (cls == UNARY))
                    || ((state == T5) && ((cls == R3) || (cls == IMM)))
                    || (state == T6);

    function automatic logic [NUM_REGS-1:0] sel(input logic [3:0] r);
        return NUM_REGS'(1) << r;
    endfunction

    // State register and memory-wait counter.
    always_ff @(posedge clock) begin
        if (clear) begin
            state    <= IDLE;
            wait_cnt <= '0;
        end else begin
            case (state)
                IDLE: if (bus.start) state <= T0;
                T0: begin
                    state    <= T1;
                    wait_cnt <= '0;
                end
                T1: begin
                    if (timeout) begin
                        state    <= IDLE;
                        wait_cnt <= '0;
                    end else if (bus.mem_ready) begin
                        state    <= T2;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                T2: state <= T3;
                T3: state <= bad ? IDLE : T4;
                T4: state <= last_step ? (bus.start ? T0 : IDLE) : T5;
                T5: state <= last_step ? (bus.start ? T0 : IDLE) : T6;
                T6: state <= bus.start ? T0 : IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Strobe decode from the registered state and the IR fields only.
    always_comb begin
        state_t eff;
        eff = ((state == T3) && bad) ? ILL : state;
        bus.busy       = (state != IDLE);
        bus.done       = last_step;
        bus.illegal    = 1'b0;
        bus.mem_err    = 1'b0;
        bus.pc_out     = 1'b0;
        bus.mar_in     = 1'b0;
        bus.inc_pc     = 1'b0;
        bus.pc_in      = 1'b0;
        bus.read       = 1'b0;
        bus.mdr_in     = 1'b0;
        bus.mdr_out    = 1'b0;
        bus.ir_in      = 1'b0;
        bus.y_in       = 1'b0;
        bus.z_in       = 1'b0;
        bus.z_low_out  = 1'b0;
        bus.z_high_out = 1'b0;
        bus.hi_in      = 1'b0;
        bus.lo_in      = 1'b0;
        bus.c_out      = 1'b0;
        bus.alu_op     = '0;
        bus.rin        = '0;
        bus.rout       = '0;
        case (eff)
            T0: begin
                bus.pc_out = 1'b1;
                bus.mar_in = 1'b1;
                bus.inc_pc = 1'b1;
                bus.z_in   = 1'b1;
            end
            T1: begin
                // The incremented PC is written back only once, even if memory stalls.
                if (wait_cnt == '0) begin
                    bus.z_low_out = 1'b1;
                    bus.pc_in     = 1'b1;
                end
                // On an aborted fetch, stop requesting and do not load MDR.
                if (timeout) begin
                    bus.mem_err = 1'b1;
                end else begin
                    bus.read   = 1'b1;
                    bus.mdr_in = 1'b1;
                end
            end
            T2: begin
                bus.mdr_out = 1'b1;
                bus.ir_in   = 1'b1;
            end
            T3: begin
                case (cls)
                    UNARY: begin
                        bus.rout   = sel(rb);
                        bus.alu_op = dec_alu_op;
                        bus.z_in   = 1'b1;
                    end
                    MULDIV: begin
                        bus.rout = sel(ra);
                        bus.y_in = 1'b1;
                    end
                    default: begin
                        bus.rout = sel(rb);
                        bus.y_in = 1'b1;
                    end
                endcase
            end
            T4: begin
                case (cls)
                    UNARY: begin
                        bus.z_low_out = 1'b1;
                        bus.rin       = sel(ra);
                    end
                    MULDIV: begin
                        bus.rout   = sel(rb);
                        bus.alu_op = dec_alu_op;
                        bus.z_in   = 1'b1;
                    end
                    IMM: begin
`ifdef IMM_OPS_EN
                        bus.c_out  = 1'b1;
`endif
                        bus.alu_op = dec_alu_op;
                        bus.z_in   = 1'b1;
                    end
                    default: begin
                        bus.rout   = sel(rc);
                        bus.alu_op = dec_alu_op;
                        bus.z_in   = 1'b1;
                    end
                endcase
            end
            T5: begin
                bus.z_low_out = 1'b1;
                if (cls == MULDIV) bus.lo_in = 1'b1;
                else               bus.rin   = sel(ra);
            end
            T6: begin
                bus.z_high_out = 1'b1;
                bus.hi_in      = 1'b1;
            end
            ILL: bus.illegal = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_alu_instr_sequencer.sv
// Randomized bench for alu_instr_sequencer. For each instruction, a list-level model builds
// the expected strobe vector of every cycle from the instruction-class step tables. The bench
// compares that list against the DUT one cycle at a time.
module tb_alu_instr_sequencer;

    localparam int NUM_REGS    = 16;
    localparam int ALUOP_W     = 4;
    localparam int MEM_TIMEOUT = 15;

    typedef struct packed {
        logic busy, done, illegal, mem_err;
        logic pc_out, mar_in, inc_pc, pc_in, read, mdr_in, mdr_out, ir_in;
        logic y_in, z_in, z_low_out, z_high_out, hi_in, lo_in, c_out;
        logic [3:0]  alu_op;
        logic [15:0] rin;
        logic [15:0] rout;
    } obs_t;

    logic clock = 1'b0;
    logic clear = 1'b1;
    always #5 clock = ~clock;

    alu_instr_sequencer_if #(.NUM_REGS(NUM_REGS), .ALUOP_W(ALUOP_W)) bus ();

    alu_instr_sequencer #(
        .NUM_REGS(NUM_REGS), .ALUOP_W(ALUOP_W), .MEM_TIMEOUT(MEM_TIMEOUT)
    ) dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus)
    );

    int   n_checks = 0;
    int   n_errors = 0;
    obs_t exp_q[$];
    bit   mr_q[$];
    bit   in_t0 = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic obs_t sample();
        obs_t o;
        o.busy = bus.busy;       o.done = bus.done;       o.illegal = bus.illegal;
        o.mem_err = bus.mem_err; o.pc_out = bus.pc_out;   o.mar_in = bus.mar_in;
        o.inc_pc = bus.inc_pc;   o.pc_in = bus.pc_in;     o.read = bus.read;
        o.mdr_in = bus.mdr_in;   o.mdr_out = bus.mdr_out; o.ir_in = bus.ir_in;
        o.y_in = bus.y_in;       o.z_in = bus.z_in;       o.z_low_out = bus.z_low_out;
        o.z_high_out = bus.z_high_out; o.hi_in = bus.hi_in; o.lo_in = bus.lo_in;
        o.c_out = bus.c_out;     o.alu_op = bus.alu_op;   o.rin = bus.rin;
        o.rout = bus.rout;
        return o;
    endfunction

    // Instruction set from the bench's point of view: 0=R3 1=UNARY 2=MULDIV 3=IMM 4=illegal.
    function automatic int cls_of(input logic [4:0] op);
        if (op >= 5'd3 && op <= 5'd11) return 0;
        if (op == 5'd17 || op == 5'd18) return 1;
        if (op == 5'd15 || op == 5'd16) return 2;
`ifdef IMM_OPS_EN
        if (op >= 5'd12 && op <= 5'd14) return 3;
`endif
        return 4;
    endfunction

    function automatic logic [3:0] alu_of(input logic [4:0] op);
        case (op)
            5'd3, 5'd12: return 4'd1;
            5'd4:        return 4'd2;
            5'd5, 5'd13: return 4'd3;
            5'd6, 5'd14: return 4'd4;
            5'd7:        return 4'd8;
            5'd8:        return 4'd9;
            5'd9:        return 4'd5;
            5'd10:       return 4'd6;
            5'd11:       return 4'd7;
            5'd15:       return 4'd10;
            5'd16:       return 4'd11;
            5'd17:       return 4'd12;
            5'd18:       return 4'd13;
            default:     return 4'd0;
        endcase
    endfunction

    function automatic logic [15:0] reg_bit(input logic [3:0] r);
        return 16'(1) << r;
    endfunction

    function automatic void push(input obs_t e, input bit mr);
        exp_q.push_back(e);
        mr_q.push_back(mr);
    endfunction

    // Expected per-cycle trace from T0 onward. wait_n is the number of T1 cycles without mem_ready.
    function automatic void build(input logic [31:0] ir_v, input int wait_n);
        obs_t e;
        logic [3:0] ra, rb, rc, a;
        int c;
        ra = ir_v[26:23]; rb = ir_v[22:19]; rc = ir_v[18:15];
        c  = cls_of(ir_v[31:27]);
        a  = alu_of(ir_v[31:27]);
        exp_q.delete();
        mr_q.delete();
        e = '0; e.busy = 1; e.pc_out = 1; e.mar_in = 1; e.inc_pc = 1; e.z_in = 1;
        push(e, 1'($urandom_range(0, 1)));
        for (int k = 0; k <= wait_n && k < MEM_TIMEOUT; k++) begin
            e = '0; e.busy = 1; e.read = 1; e.mdr_in = 1;
            if (k == 0) begin e.pc_in = 1; e.z_low_out = 1; end
            push(e, k >= wait_n);
        end
        if (wait_n >= MEM_TIMEOUT) begin
            e = '0; e.busy = 1; e.mem_err = 1;
            push(e, 1'b0);
            return;
        end
        e = '0; e.busy = 1; e.mdr_out = 1; e.ir_in = 1;
        push(e, 1'($urandom_range(0, 1)));
        case (c)
            0, 3: begin
                e = '0; e.busy = 1; e.rout = reg_bit(rb); e.y_in = 1; push(e, 1'b0);
                e = '0; e.busy = 1; e.alu_op = a; e.z_in = 1;
                if (c == 0) e.rout = reg_bit(rc); else e.c_out = 1;
                push(e, 1'b1);
                e = '0; e.busy = 1; e.z_low_out = 1; e.rin = reg_bit(ra); e.done = 1; push(e, 1'b0);
            end
            1: begin
                e = '0; e.busy = 1; e.rout = reg_bit(rb); e.alu_op = a; e.z_in = 1; push(e, 1'b1);
                e = '0; e.busy = 1; e.z_low_out = 1; e.rin = reg_bit(ra); e.done = 1; push(e, 1'b0);
            end
            2: begin
                e = '0; e.busy = 1; e.rout = reg_bit(ra); e.y_in = 1; push(e, 1'b0);
                e = '0; e.busy = 1; e.rout = reg_bit(rb); e.alu_op = a; e.z_in = 1; push(e, 1'b1);
                e = '0; e.busy = 1; e.z_low_out = 1; e.lo_in = 1; push(e, 1'b0);
                e = '0; e.busy = 1; e.z_high_out = 1; e.hi_in = 1; e.done = 1; push(e, 1'b1);
            end
            default: begin
                e = '0; e.busy = 1; e.illegal = 1; push(e, 1'b0);
            end
        endcase
    endfunction

    // Entered one cycle before T0: start is already high in IDLE, or the previous instruction chained.
    task automatic run_instr(input string name, input logic [31:0] ir_v, input int wait_n,
                             input bit chain, input int abort_at);
        int last;
        bit stop;
        build(ir_v, wait_n);
        last = exp_q.size() - 1;
        stop = 1'b0;
        for (int i = 0; i <= last && !stop; i++) begin
            @(negedge clock);
            if (i == 0) bus.ir = ir_v;
            bus.mem_ready = mr_q[i];
            bus.start = (i == last) ? chain : 1'($urandom_range(0, 1));
            #1;
            check($sformatf("%s step%0d", name, i), 64'(sample()), 64'(exp_q[i]));
            if (i == abort_at) begin
                clear = 1'b1;
                bus.start = 1'b0;
                stop = 1'b1;
            end
        end
        in_t0 = 1'b0;
        if (stop) begin
            @(negedge clock);
            #1;
            check($sformatf("%s after clear", name), 64'(sample()), 64'(0));
            clear = 1'b0;
        end else if (chain && exp_q[last].done) begin
            in_t0 = 1'b1;
        end else begin
            @(negedge clock);
            bus.start = 1'b0;
            #1;
            check($sformatf("%s idle", name), 64'(sample()), 64'(0));
        end
    endtask

    task automatic issue(input string name, input logic [31:0] ir_v, input int wait_n,
                         input bit chain, input int abort_at);
        if (!in_t0) bus.start = 1'b1;
        run_instr(name, ir_v, wait_n, chain, abort_at);
    endtask

    function automatic logic [31:0] mk_ir(input logic [4:0] op, input logic [3:0] ra,
                                          input logic [3:0] rb, input logic [3:0] rc);
        return {op, ra, rb, rc, 15'($urandom)};
    endfunction

    initial begin
        bus.start     = 1'b1;
        bus.mem_ready = 1'b0;
        bus.ir        = '0;
        clear         = 1'b1;
        repeat (2) begin
            @(negedge clock);
            #1;
            check("clear", 64'(sample()), 64'(0));
        end
        clear = 1'b0;
        run_instr("rol_r7_r0_r4", 32'h43820000, 0, 1'b0, -1);
        issue("add_wait3", mk_ir(5'd3, 4'd1, 4'd2, 4'd3), 3, 1'b0, -1);
        issue("timeout", mk_ir(5'd4, 4'd5, 4'd6, 4'd7), MEM_TIMEOUT, 1'b1, -1);
        issue("wait_max_ok", mk_ir(5'd7, 4'd8, 4'd9, 4'd10), MEM_TIMEOUT - 1, 1'b0, -1);
        issue("mul_chain", mk_ir(5'd15, 4'd2, 4'd3, 4'd0), 0, 1'b1, -1);
        issue("neg_after_mul", mk_ir(5'd17, 4'd11, 4'd12, 4'd0), 1, 1'b0, -1);
        issue("op_1f", mk_ir(5'h1F, 4'd4, 4'd5, 4'd6), 0, 1'b1, -1);
        issue("addi", mk_ir(5'd12, 4'd13, 4'd14, 4'd0), 0, 1'b0, -1);
        issue("add_clear_t4", mk_ir(5'd3, 4'd15, 4'd1, 4'd2), 0, 1'b0, 4);
        for (int n = 0; n < 40; n++) begin
            issue($sformatf("rnd%0d", n),
                  mk_ir(5'($urandom_range(0, 20)), 4'($urandom), 4'($urandom), 4'($urandom)),
                  $urandom_range(0, 4), 1'($urandom_range(0, 1)), -1);
        end
        if (in_t0) begin
            run_instr("final", mk_ir(5'd5, 4'd1, 4'd1, 4'd1), 0, 1'b0, -1);
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
